// File: rtl/completer_ram_writer.sv
// Writes the aligned completer beat stream into a ring-buffer data RAM and
// emits one descriptor per finished packet; consumers free RAM via release.
module completer_ram_writer #(
   parameter int NVME_DATA_WIDTH = 256,
   parameter int RAM_ADDR_WIDTH  = 7
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          srst,
   input  logic                          in_valid,
   input  logic                          in_sof,
   input  logic                          in_eof,
   input  logic [63:0]                   in_address,
   input  logic [10:0]                   in_length,
   input  logic [NVME_DATA_WIDTH/8-1:0]  in_be,
   input  logic [NVME_DATA_WIDTH-1:0]    in_data,
   output logic                          in_ready,
   output logic                          ram_wr_en,
   output logic [RAM_ADDR_WIDTH-1:0]     ram_wr_addr,
   output logic [NVME_DATA_WIDTH/8-1:0]  ram_wr_be,
   output logic [NVME_DATA_WIDTH-1:0]    ram_wr_data,
   output logic                          desc_valid,
   output logic [63:0]                   desc_address,
   output logic [10:0]                   desc_length,
   output logic [RAM_ADDR_WIDTH-1:0]     desc_start,
   output logic [RAM_ADDR_WIDTH:0]       desc_beats,
   output logic                          desc_err,
   input  logic                          desc_ready,
   input  logic                          rel_valid,
   input  logic [RAM_ADDR_WIDTH:0]       rel_count,
   output logic                          err_sof,
   output logic                          err_orphan
);

   localparam int DW_PER_BEAT = NVME_DATA_WIDTH / 32;
   localparam int BE_W        = NVME_DATA_WIDTH / 8;
   localparam int RAM_DEPTH   = 2 ** RAM_ADDR_WIDTH;
   localparam int CNT_W       = RAM_ADDR_WIDTH + 1;
   localparam int SUM_W       = CNT_W + 2;

   typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;

   state_t                      state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]            free_count_q, free_count_d;
   logic [RAM_ADDR_WIDTH-1:0]   pkt_start_q, pkt_start_d;
   logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
   logic [63:0]                 addr_q, addr_d;
   logic [10:0]                 len_q, len_d;
   logic                        ram_wr_en_q, ram_wr_en_d;
   logic [RAM_ADDR_WIDTH-1:0]   ram_wr_addr_q, ram_wr_addr_d;
   logic [BE_W-1:0]             ram_wr_be_q, ram_wr_be_d;
   logic [NVME_DATA_WIDTH-1:0]  ram_wr_data_q, ram_wr_data_d;
   logic                        desc_valid_q, desc_valid_d;
   logic [63:0]                 desc_address_q, desc_address_d;
   logic [10:0]                 desc_length_q, desc_length_d;
   logic [RAM_ADDR_WIDTH-1:0]   desc_start_q, desc_start_d;
   logic [CNT_W-1:0]            desc_beats_q, desc_beats_d;
   logic                        desc_err_q, desc_err_d;
   logic                        err_sof_q, err_sof_d;
   logic                        err_orphan_q, err_orphan_d;

   logic                        accept, wr_beat, abort, start_pkt, pkt_done, orphan;
   logic [RAM_ADDR_WIDTH-1:0]   wr_idx, cur_start;
   logic [CNT_W-1:0]            beats_now;
   logic [63:0]                 cur_addr;
   logic [10:0]                 cur_len, len_eff;
   logic [11:0]                 exp_beats;
   logic [SUM_W-1:0]            free_sum;

   assign in_ready = (free_count_q != '0) & ~(desc_valid_q & ~desc_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d       = state_q;
      wr_beat       = 1'b0;
      abort         = 1'b0;
      start_pkt     = 1'b0;
      pkt_done      = 1'b0;
      orphan        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  start_pkt = 1'b1;
                  wr_beat   = 1'b1;
                  pkt_done  = in_eof;
                  state_d   = in_eof ? ST_IDLE : ST_DATA;
               end else begin
                  orphan = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               wr_beat   = 1'b1;
               abort     = in_sof;
               start_pkt = in_sof;
               pkt_done  = in_eof;
               state_d   = in_eof ? ST_IDLE : ST_DATA;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An aborting sof reuses the slots of the packet it kills.
      wr_idx    = abort ? pkt_start_q : wr_ptr_q;
      beats_now = (start_pkt ? '0 : beat_cnt_q) + CNT_W'(1);
      cur_addr  = start_pkt ? in_address : addr_q;
      cur_len   = start_pkt ? in_length : len_q;
      cur_start = start_pkt ? wr_idx : pkt_start_q;

      len_eff   = (cur_len == 11'd0) ? 11'd1024 : cur_len;
      exp_beats = ({1'b0, len_eff} + 12'(DW_PER_BEAT - 1)) / 12'(DW_PER_BEAT);

      pkt_start_d = cur_start;
      addr_d      = cur_addr;
      len_d       = cur_len;
      beat_cnt_d  = wr_beat ? beats_now : beat_cnt_q;
      wr_ptr_d    = wr_beat ? wr_idx + RAM_ADDR_WIDTH'(1) : wr_ptr_q;

      free_sum = SUM_W'(free_count_q)
               + (abort ? SUM_W'(beat_cnt_q) : '0)
               + (rel_valid ? SUM_W'(rel_count) : '0)
               - SUM_W'(wr_beat);
      free_count_d = (free_sum > SUM_W'(RAM_DEPTH)) ? CNT_W'(RAM_DEPTH) : free_sum[CNT_W-1:0];

      ram_wr_en_d   = wr_beat;
      ram_wr_addr_d = wr_beat ? wr_idx : ram_wr_addr_q;
      ram_wr_be_d   = wr_beat ? in_be : ram_wr_be_q;
      ram_wr_data_d = wr_beat ? in_data : ram_wr_data_q;

      desc_valid_d   = desc_valid_q & ~desc_ready;
      desc_address_d = desc_address_q;
      desc_length_d  = desc_length_q;
      desc_start_d   = desc_start_q;
      desc_beats_d   = desc_beats_q;
      desc_err_d     = desc_err_q;
      if (pkt_done) begin
         desc_valid_d   = 1'b1;
         desc_address_d = cur_addr;
         desc_length_d  = cur_len;
         desc_start_d   = cur_start;
         desc_beats_d   = beats_now;
         desc_err_d     = exp_beats != 12'(beats_now);
      end

      err_sof_d    = abort;
      err_orphan_d = orphan;

      if (srst) begin
         state_d        = ST_IDLE;
         wr_ptr_d       = '0;
         free_count_d   = CNT_W'(RAM_DEPTH);
         pkt_start_d    = '0;
         beat_cnt_d     = '0;
         addr_d         = '0;
         len_d          = '0;
         ram_wr_en_d    = 1'b0;
         ram_wr_addr_d  = '0;
         ram_wr_be_d    = '0;
         ram_wr_data_d  = '0;
         desc_valid_d   = 1'b0;
         desc_address_d = '0;
         desc_length_d  = '0;
         desc_start_d   = '0;
         desc_beats_d   = '0;
         desc_err_d     = 1'b0;
         err_sof_d      = 1'b0;
         err_orphan_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= ST_IDLE;
         wr_ptr_q       <= '0;
         free_count_q   <= CNT_W'(RAM_DEPTH);
         pkt_start_q    <= '0;
         beat_cnt_q     <= '0;
         addr_q         <= '0;
         len_q          <= '0;
         ram_wr_en_q    <= 1'b0;
         ram_wr_addr_q  <= '0;
         ram_wr_be_q    <= '0;
         ram_wr_data_q  <= '0;
         desc_valid_q   <= 1'b0;
         desc_address_q <= '0;
         desc_length_q  <= '0;
         desc_start_q   <= '0;
         desc_beats_q   <= '0;
         desc_err_q     <= 1'b0;
         err_sof_q      <= 1'b0;
         err_orphan_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         free_count_q   <= free_count_d;
         pkt_start_q    <= pkt_start_d;
         beat_cnt_q     <= beat_cnt_d;
         addr_q         <= addr_d;
         len_q          <= len_d;
         ram_wr_en_q    <= ram_wr_en_d;
         ram_wr_addr_q  <= ram_wr_addr_d;
         ram_wr_be_q    <= ram_wr_be_d;
         ram_wr_data_q  <= ram_wr_data_d;
         desc_valid_q   <= desc_valid_d;
         desc_address_q <= desc_address_d;
         desc_length_q  <= desc_length_d;
         desc_start_q   <= desc_start_d;
         desc_beats_q   <= desc_beats_d;
         desc_err_q     <= desc_err_d;
         err_sof_q      <= err_sof_d;
         err_orphan_q   <= err_orphan_d;
      end
   end

   assign ram_wr_en    = ram_wr_en_q;
   assign ram_wr_addr  = ram_wr_addr_q;
   assign ram_wr_be    = ram_wr_be_q;
   assign ram_wr_data  = ram_wr_data_q;
   assign desc_valid   = desc_valid_q;
   assign desc_address = desc_address_q;
   assign desc_length  = desc_length_q;
   assign desc_start   = desc_start_q;
   assign desc_beats   = desc_beats_q;
   assign desc_err     = desc_err_q;
   assign err_sof      = err_sof_q;
   assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_completer_ram_writer.sv
// Directed bench for completer_ram_writer: ring wrap, aborts, orphans,
// descriptor backpressure, release saturation and both resets.
module tb_completer_ram_writer;

   localparam int W   = 256;
   localparam int AW  = 7;
   localparam int BEW = W / 8;

   logic           clk = 1'b0;
   logic           rstn, srst;
   logic           in_valid, in_sof, in_eof;
   logic [63:0]    in_address;
   logic [10:0]    in_length;
   logic [BEW-1:0] in_be;
   logic [W-1:0]   in_data;
   logic           in_ready;
   logic           ram_wr_en;
   logic [AW-1:0]  ram_wr_addr;
   logic [BEW-1:0] ram_wr_be;
   logic [W-1:0]   ram_wr_data;
   logic           desc_valid;
   logic [63:0]    desc_address;
   logic [10:0]    desc_length;
   logic [AW-1:0]  desc_start;
   logic [AW:0]    desc_beats;
   logic           desc_err;
   logic           desc_ready;
   logic           rel_valid;
   logic [AW:0]    rel_count;
   logic           err_sof, err_orphan;

   int checks   = 0;
   int failures = 0;

   completer_ram_writer #(.NVME_DATA_WIDTH(W), .RAM_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .srst(srst),
      .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
      .in_address(in_address), .in_length(in_length), .in_be(in_be), .in_data(in_data),
      .in_ready(in_ready),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_be(ram_wr_be), .ram_wr_data(ram_wr_data),
      .desc_valid(desc_valid), .desc_address(desc_address), .desc_length(desc_length),
      .desc_start(desc_start), .desc_beats(desc_beats), .desc_err(desc_err), .desc_ready(desc_ready),
      .rel_valid(rel_valid), .rel_count(rel_count),
      .err_sof(err_sof), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Presents one beat, waits (bounded) for in_ready, returns #1 after the accept edge.
   task automatic send_beat(input logic sof, input logic eof, input logic [63:0] addr,
                            input logic [10:0] len, input logic [63:0] tag);
      int n;
      n          = 0;
      in_valid   = 1'b1;
      in_sof     = sof;
      in_eof     = eof;
      in_address = addr;
      in_length  = len;
      in_be      = tag[31:0] ^ 32'hFFFF_0000;
      in_data    = {4{tag}};
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check_val("ready_timeout", 64'(in_ready), 64'd1);
      end else begin
         @(posedge clk); #1;
         $display("beat sof=%0b eof=%0b tag=%0d wr_en=%0b idx=%0d", sof, eof, tag, ram_wr_en, ram_wr_addr);
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
   endtask

   task automatic consume_desc();
      desc_ready = 1'b1;
      @(posedge clk); #1;
      desc_ready = 1'b0;
   endtask

   task automatic release_beats(input int cnt);
      rel_valid = 1'b1;
      rel_count = (AW+1)'(cnt);
      @(posedge clk); #1;
      rel_valid = 1'b0;
      rel_count = '0;
      $display("release count=%0d free=%0d", cnt, dut.free_count_q);
   endtask

   initial begin
      rstn = 1'b0; srst = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      in_address = '0; in_length = '0; in_be = '0; in_data = '0;
      desc_ready = 1'b0; rel_valid = 1'b0; rel_count = '0;

      #12;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_wr_en", 64'(ram_wr_en), 64'd0);
      check_val("rst_desc_valid", 64'(desc_valid), 64'd0);
      check_val("rst_err", 64'({err_sof, err_orphan}), 64'd0);
      #5 rstn = 1'b1;
      @(posedge clk); #1;

      // single-beat packet
      send_beat(1'b1, 1'b1, 64'h1000, 11'd8, 64'hA5);
      check_val("p1_wr_en", 64'(ram_wr_en), 64'd1);
      check_val("p1_wr_idx", 64'(ram_wr_addr), 64'd0);
      check_val("p1_wr_data", ram_wr_data[63:0], 64'hA5);
      check_val("p1_wr_be", 64'(ram_wr_be), 64'hFFFF_00A5);
      check_val("p1_desc_valid", 64'(desc_valid), 64'd1);
      check_val("p1_desc_addr", desc_address, 64'h1000);
      check_val("p1_desc_len", 64'(desc_length), 64'd8);
      check_val("p1_desc_start", 64'(desc_start), 64'd0);
      check_val("p1_desc_beats", 64'(desc_beats), 64'd1);
      check_val("p1_desc_err", 64'(desc_err), 64'd0);
      check_val("p1_ready_blocked", 64'(in_ready), 64'd0);
      desc_ready = 1'b1; #1;
      check_val("p1_ready_comb", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      desc_ready = 1'b0;
      check_val("p1_desc_cleared", 64'(desc_valid), 64'd0);
      check_val("p1_wr_en_drop", 64'(ram_wr_en), 64'd0);

      // orphan beat outside a packet
      send_beat(1'b0, 1'b0, 64'h0, 11'd8, 64'h77);
      check_val("orph_pulse", 64'(err_orphan), 64'd1);
      check_val("orph_no_write", 64'(ram_wr_en), 64'd0);
      check_val("orph_free", 64'(dut.free_count_q), 64'd127);
      @(posedge clk); #1;
      check_val("orph_pulse_end", 64'(err_orphan), 64'd0);
      release_beats(1);

      // 125-beat packet moves wr_ptr to 126
      for (int i = 0; i < 125; i++)
         send_beat(i == 0, i == 124, 64'h2000, 11'd1000, 64'(i));
      check_val("big_last_idx", 64'(ram_wr_addr), 64'd125);
      check_val("big_desc_start", 64'(desc_start), 64'd1);
      check_val("big_desc_beats", 64'(desc_beats), 64'd125);
      check_val("big_desc_err", 64'(desc_err), 64'd0);
      consume_desc();
      release_beats(125);

      // 4-beat packet wrapping 126,127,0,1
      for (int i = 0; i < 4; i++) begin
         send_beat(i == 0, i == 3, 64'h3000, 11'd32, 64'(100 + i));
         check_val($sformatf("wrap_idx%0d", i), 64'(ram_wr_addr), 64'((126 + i) % 128));
      end
      check_val("wrap_desc_start", 64'(desc_start), 64'd126);
      check_val("wrap_desc_beats", 64'(desc_beats), 64'd4);
      check_val("wrap_desc_err", 64'(desc_err), 64'd0);
      check_val("wrap_free", 64'(dut.free_count_q), 64'd124);
      consume_desc();
      release_beats(4);

      // abort: sof, beat, then a fresh sof at idx 2
      send_beat(1'b1, 1'b0, 64'h4000, 11'd64, 64'd200);
      send_beat(1'b0, 1'b0, 64'h0, 11'd0, 64'd201);
      check_val("abt_pre_idx", 64'(ram_wr_addr), 64'd3);
      send_beat(1'b1, 1'b0, 64'h5000, 11'd16, 64'd202);
      check_val("abt_err_sof", 64'(err_sof), 64'd1);
      check_val("abt_rewind_idx", 64'(ram_wr_addr), 64'd2);
      check_val("abt_free", 64'(dut.free_count_q), 64'd127);
      send_beat(1'b0, 1'b1, 64'h0, 11'd0, 64'd203);
      check_val("abt_sof_end", 64'(err_sof), 64'd0);
      check_val("abt_desc_addr", desc_address, 64'h5000);
      check_val("abt_desc_len", 64'(desc_length), 64'd16);
      check_val("abt_desc_start", 64'(desc_start), 64'd2);
      check_val("abt_desc_beats", 64'(desc_beats), 64'd2);
      check_val("abt_desc_err", 64'(desc_err), 64'd0);
      consume_desc();
      release_beats(2);

      // length 16 needs 2 beats, only 1 sent
      send_beat(1'b1, 1'b1, 64'h6000, 11'd16, 64'd300);
      check_val("short_desc_err", 64'(desc_err), 64'd1);
      check_val("short_idx", 64'(ram_wr_addr), 64'd4);
      consume_desc();
      release_beats(1);

      // len 0 (1024 dw) = 128 beats fills the whole RAM
      for (int i = 0; i < 128; i++)
         send_beat(i == 0, i == 127, 64'h7000, 11'd0, 64'(400 + i));
      check_val("full_last_idx", 64'(ram_wr_addr), 64'd4);
      check_val("full_desc_start", 64'(desc_start), 64'd5);
      check_val("full_desc_beats", 64'(desc_beats), 64'd128);
      check_val("full_desc_err", 64'(desc_err), 64'd0);
      check_val("full_ready", 64'(in_ready), 64'd0);
      desc_ready = 1'b1; #1;
      check_val("full_ready_nofree", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      desc_ready = 1'b0;
      release_beats(128);
      check_val("full_released_ready", 64'(in_ready), 64'd1);

      // release saturation with a simultaneous write
      send_beat(1'b1, 1'b0, 64'h8000, 11'd64, 64'd600);
      send_beat(1'b0, 1'b0, 64'h0, 11'd0, 64'd601);
      send_beat(1'b0, 1'b0, 64'h0, 11'd0, 64'd602);
      check_val("sat_free_pre", 64'(dut.free_count_q), 64'd125);
      rel_valid = 1'b1; rel_count = 8'd10;
      send_beat(1'b0, 1'b0, 64'h0, 11'd0, 64'd603);
      rel_valid = 1'b0; rel_count = '0;
      check_val("sat_free", 64'(dut.free_count_q), 64'd128);
      check_val("sat_idx", 64'(ram_wr_addr), 64'd8);

      // async reset mid-packet
      rstn = 1'b0; #2;
      check_val("arst_wr_en", 64'(ram_wr_en), 64'd0);
      check_val("arst_wr_addr", 64'(ram_wr_addr), 64'd0);
      check_val("arst_wr_data", ram_wr_data[63:0], 64'd0);
      check_val("arst_desc", 64'({desc_valid, desc_err, desc_beats}), 64'd0);
      check_val("arst_in_ready", 64'(in_ready), 64'd1);
      #2 rstn = 1'b1;
      @(posedge clk); #1;
      send_beat(1'b1, 1'b1, 64'h9000, 11'd8, 64'd700);
      check_val("arst_restart_idx", 64'(ram_wr_addr), 64'd0);
      check_val("arst_restart_start", 64'(desc_start), 64'd0);
      check_val("arst_restart_sof", 64'(err_sof), 64'd0);
      consume_desc();

      // sync reset mid-packet
      send_beat(1'b1, 1'b0, 64'hA000, 11'd64, 64'd800);
      send_beat(1'b0, 1'b0, 64'h0, 11'd0, 64'd801);
      check_val("srst_pre_idx", 64'(ram_wr_addr), 64'd2);
      srst = 1'b1;
      @(posedge clk); #1;
      srst = 1'b0;
      check_val("srst_desc", 64'(desc_valid), 64'd0);
      check_val("srst_wr_en", 64'(ram_wr_en), 64'd0);
      check_val("srst_free", 64'(dut.free_count_q), 64'd128);
      send_beat(1'b1, 1'b1, 64'hB000, 11'd8, 64'd900);
      check_val("srst_restart_idx", 64'(ram_wr_addr), 64'd0);
      check_val("srst_restart_sof", 64'(err_sof), 64'd0);
      check_val("srst_restart_beats", 64'(desc_beats), 64'd1);
      check_val("srst_restart_addr", desc_address, 64'hB000);
      consume_desc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
